mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide execution unit owning the architectural HI/LO registers.
- Sits directly downstream of the ALU control decoder and consumes its 6-bit `alu_ctrl_in` code.
- Executes mult/multu/div/divu iteratively and asserts `busy` so the pipeline controller can stall mfhi/mflo and further mult/div issue.
- Also services mthi/mtlo writes.

Parameters:
- `ITER`, 32: iteration count for multiply and divide; fixed at the 32-bit operand width.

Ports:
- `clk` — input, 1 — rising-edge clock.
- `reset_n` — input, 1 — asynchronous, active-low reset.
- `start` — input, 1 — request to launch the operation named by `alu_ctrl_in`.
- `alu_ctrl_in` — input, 6 — decoder code: 0x0F mult, 0x10 multu, 0x11 div, 0x12 divu; other codes are not mult/div.
- `op_a` — input, 32 — rs value (multiplicand / dividend).
- `op_b` — input, 32 — rt value (multiplier / divisor).
- `wr_hi` — input, 1 — mthi strobe.
- `wr_lo` — input, 1 — mtlo strobe.
- `wr_data` — input, 32 — mthi/mtlo data.
- `hi` — output, 32 — HI register.
- `lo` — output, 32 — LO register.
- `busy` — output, 1 — high while an operation is in flight.
- `done` — output, 1 — one-cycle pulse in the cycle HI/LO first show a new result.

Behaviour:
- Reset (`reset_n` low, asynchronous) clears:
  - `hi`, `lo`, `busy`, `done` to 0;
  - FSM to IDLE, iteration counter to 0, all datapath registers to 0.
- Reset asserted mid-operation aborts it immediately. HI/LO are not updated with a partial result.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - `start`=1 with code 0x0F..0x12 is accepted at that edge.
  - Operands are captured, the signed/unsigned flag is latched, and the FSM moves to RUN with counter=0.
  - `start` with any other code is ignored.
- Signed ops (mult, div):
  - Operate on magnitudes. Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
  - Latch `neg_res` = sign(a) XOR sign(b) and `neg_rem` = sign(a).
- Multiply:
  - Shift-add, one multiplier bit per edge, LSB first.
  - 64-bit accumulator.
- Divide:
  - Restoring, one quotient bit per edge, MSB first.
  - 33-bit partial remainder.
- RUN:
  - Each edge performs one iteration and increments the counter.
  - The edge completing iteration `ITER` moves the FSM to FINISH.
- FINISH (one edge):
  - Applies sign fix-up.
  - mult/multu: `{hi,lo}` <= product, two's-complement negated if `neg_res`.
  - div/divu: `lo` <= quotient, negated if `neg_res`; `hi` <= remainder, negated if `neg_rem`.
  - `done` <= 1 for exactly one cycle; FSM returns to IDLE.
- Latency:
  - Acceptance edge E0; iterations E1..E32; HI/LO and `done` update at E33.
  - `busy` is high after E0 through E33 and low after E33.
  - `busy` is combinational: state != IDLE.
- Divide by zero (`op_b`==0 on div/divu):
  - Detected at E0; the FSM goes directly to FINISH, so the result appears at E1.
  - Result: `lo`=0xFFFFFFFF, `hi`=`op_a`, regardless of signedness.
- Overflow:
  - div 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. This is wrap semantics; no exception.
- `start` while `busy`: ignored. The in-flight operation is unaffected. The controller must stall, not re-issue.
- `wr_hi`/`wr_lo`:
  - Honoured only when FSM is IDLE. They write `wr_data` at the edge and are visible the next cycle.
  - Ignored while `busy`.
  - Both asserted writes the same value to both registers.
- `wr_*` and an accepted `start` in the same IDLE cycle: the write is applied at E0, and the operation result later overwrites it at completion.
- `hi`/`lo` hold their value at all times except the FINISH edge and IDLE writes.
- Operands are captured at E0. `op_a`/`op_b` may change freely afterwards.

Test Plan:
- multu 0xFFFFFFFF × 0xFFFFFFFF → at E33: `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` pulses one cycle; `busy` high for exactly 33 cycles.
- mult 0xFFFFFFFD (−3) × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; mult 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- div 0xFFFFFFF9 (−7) ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; divu 7 ÷ 2 → `lo`=3, `hi`=1; div 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- divu 0x1234 ÷ 0 → `done` at E1, `lo`=0xFFFFFFFF, `hi`=0x1234; `busy` high for one cycle only.
- Launch multu 3 × 4; at E10 pulse `start` (divu) and `wr_lo`=0xAAAA → both ignored; final `hi`=0, `lo`=12. Then in IDLE, `wr_hi`=0x55 → `hi`=0x55 next cycle.
- Launch div; drop `reset_n` at E15 → `busy`/`done`/`hi`/`lo` all 0 immediately; after release, a new mult 2 × 3 gives `lo`=6 at E33.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply (LSB first) and
// restoring divide (MSB first), one bit per clock, with sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  alu_ctrl_in,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  // Handshake: an op is accepted on any edge where start is high, the code is
  // mult/multu/div/divu and busy is low. Start is ignored while busy. done
  // pulses for one cycle when HI/LO first show the result.

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [5:0] OP_MULT  = 6'h0F;
  localparam logic [5:0] OP_MULTU = 6'h10;
  localparam logic [5:0] OP_DIV   = 6'h11;
  localparam logic [5:0] OP_DIVU  = 6'h12;

  localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] a_q, a_d;       // multiplicand (mult) or divisor (div)
  logic [63:0] acc_q, acc_d;   // product/multiplier, or quotient/dividend in [31:0]
  logic [32:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        is_md, op_signed, op_div;
  logic [31:0] a_mag, b_mag;
  logic [32:0] msum, shifted;
  logic        ge;
  logic [63:0] prod_fix;

  assign is_md     = (alu_ctrl_in >= OP_MULT) && (alu_ctrl_in <= OP_DIVU);
  assign op_signed = (alu_ctrl_in == OP_MULT) || (alu_ctrl_in == OP_DIV);
  assign op_div    = (alu_ctrl_in == OP_DIV) || (alu_ctrl_in == OP_DIVU);
  // Negating 0x80000000 yields itself, which is the correct unsigned magnitude.
  assign a_mag     = (op_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign b_mag     = (op_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

  assign msum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  assign shifted  = {rem_q[31:0], acc_q[31]};
  assign ge       = (shifted >= {1'b0, a_q});
  assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    a_d       = a_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start && is_md) begin
          cnt_d = 6'd0;
          rem_d = 33'd0;
          if (op_div && (op_b == 32'd0)) begin
            // Divide by zero bypasses RUN; FINISH copies acc straight to HI/LO.
            state_d   = S_FINISH;
            is_div_d  = 1'b0;
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
            a_d       = 32'd0;
            acc_d     = {op_a, 32'hFFFF_FFFF};
          end else begin
            state_d   = S_RUN;
            is_div_d  = op_div;
            neg_res_d = op_signed && (op_a[31] ^ op_b[31]);
            neg_rem_d = op_signed && op_a[31];
            a_d       = op_div ? b_mag : a_mag;
            acc_d     = {32'd0, op_div ? a_mag : b_mag};
          end
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = {32'd0, acc_q[30:0], ge};
          rem_d = ge ? (shifted - {1'b0, a_q}) : shifted;
        end else begin
          acc_d = {msum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (is_div_q) begin
          lo_d = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
          hi_d = neg_rem_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= 32'd0;
      acc_q     <= 64'd0;
      rem_q     <= 33'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops, checked by a
// scoreboard fed from an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [5:0]  alu_ctrl_in;
  logic [31:0] op_a, op_b;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic [31:0] hi, lo;
  logic        busy, done;

  mult_div_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .alu_ctrl_in(alu_ctrl_in),
    .op_a(op_a), .op_b(op_b), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];      // expected {hi, lo}
  int          exp_cyc_q[$];  // cycle count at which done must be seen
  int          exp_busy_q[$]; // number of busy cycles preceding done
  int          last_e0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [5:0] code, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    model = 64'd0;
    case (code)
      6'h0F: begin p = sa * sb; model = p; end
      6'h10: begin up = ua * ub; model = up; end
      6'h11: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; model = {r[31:0], q[31:0]}; end
      end
      6'h12: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else model = {32'(a % b), 32'(a / b)};
      end
      default: model = 64'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    int lat;
    @(negedge clk);
    start = 1'b1; alu_ctrl_in = code; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom;  // operands must already be captured
    last_e0 = cyc;
    if (code >= 6'h0F && code <= 6'h12) begin
      lat = ((code == 6'h11 || code == 6'h12) && b == 32'd0) ? 1 : 33;
      exp_q.push_back(model(code, a, b));
      exp_cyc_q.push_back(last_e0 + lat);
      exp_busy_q.push_back(lat);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s: timeout, %0d results outstanding", name, exp_q.size());
      exp_q.delete(); exp_cyc_q.delete(); exp_busy_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic write_reg(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    wr_hi = h; wr_lo = l; wr_data = d;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   busy_run = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_run = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: done=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          check("result_hi_lo", {hi, lo}, exp_q.pop_front());
          check("done_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
          check("busy_cycles", 64'(busy_run), 64'(exp_busy_q.pop_front()));
          check("done_single_pulse", 64'(prev_done), 64'd0);
        end
        busy_run = 0;
      end
      if (busy) busy_run++;
      prev_done = done;
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0]  rc;
  logic [31:0] ra, rb;
  logic [63:0] hl;

  initial begin
    reset_n = 1'b0; start = 1'b0; alu_ctrl_in = 6'd0; op_a = 32'd0; op_b = 32'd0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(6'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_drain("multu_max");
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(6'h0F, 32'hFFFF_FFFD, 32'd5);
    wait_drain("mult_neg");
    issue(6'h0F, 32'h8000_0000, 32'h8000_0000);
    wait_drain("mult_minmin");
    check("mult_minmin_const", {hi, lo}, 64'h4000_0000_0000_0000);
    issue(6'h11, 32'hFFFF_FFF9, 32'd2);
    wait_drain("div_neg");
    check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(6'h12, 32'd7, 32'd2);
    wait_drain("divu_small");
    issue(6'h11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_drain("div_overflow");
    check("div_overflow_const", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(6'h12, 32'h1234, 32'd0);
    wait_drain("divu_zero");
    issue(6'h11, 32'hFFFF_0000, 32'd0);
    wait_drain("div_zero");

    // non-mult/div code with start must not launch anything
    issue(6'h05, 32'd9, 32'd9);
    check("bad_code_busy", {63'd0, busy}, 64'd0);

    // start and wr_lo while busy are ignored
    issue(6'h10, 32'd3, 32'd4);
    while (cyc < last_e0 + 10) @(negedge clk);
    start = 1'b1; alu_ctrl_in = 6'h12; op_a = 32'd100; op_b = 32'd7;
    wr_lo = 1'b1; wr_data = 32'hAAAA;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    check("busy_during_ignored", {63'd0, busy}, 64'd1);
    wait_drain("ignored_start");
    check("ignored_start_const", {hi, lo}, 64'd12);
    repeat (3) @(negedge clk);
    check("no_extra_busy", {63'd0, busy}, 64'd0);
    write_reg(1'b1, 1'b0, 32'h55);
    check("mthi_hi", {32'd0, hi}, 64'h55);
    check("mthi_lo_kept", {32'd0, lo}, 64'd12);
    write_reg(1'b1, 1'b1, 32'hDEAD_BEEF);
    check("mthi_mtlo_both", {hi, lo}, 64'hDEAD_BEEF_DEAD_BEEF);

    // write applied at acceptance, then overwritten by result
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'h7777;
    start = 1'b1; alu_ctrl_in = 6'h10; op_a = 32'd6; op_b = 32'd7;
    @(negedge clk);
    wr_lo = 1'b0; start = 1'b0;
    last_e0 = cyc;
    check("write_at_e0", {32'd0, lo}, 64'h7777);
    exp_q.push_back(64'd42); exp_cyc_q.push_back(last_e0 + 33); exp_busy_q.push_back(33);
    wait_drain("write_then_result");

    // asynchronous reset aborts an op mid-flight
    issue(6'h11, 32'd1000, 32'd7);
    while (cyc < last_e0 + 15) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi_lo", {hi, lo}, 64'd0);
    exp_q.delete(); exp_cyc_q.delete(); exp_busy_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    issue(6'h0F, 32'd2, 32'd3);
    wait_drain("after_reset");
    check("after_reset_const", {hi, lo}, 64'd6);

    // random ops, occasionally with edge operands and back-to-back issue
    for (int i = 0; i < 40; i++) begin
      rc = 6'(6'h0F + $urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'(($urandom_range(1, 15)));
        default: ;
      endcase
      issue(rc, ra, rb);
      wait_drain("random_op");
      hl = model(rc, ra, rb);
      check("random_hold", {hi, lo}, hl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
